// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial a-b using one full-subtractor cell and a borrow flop, LSB first.
module serial_sub_ctrl #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dif,
  output logic             bout
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_r, r_dif, w_rn;
  logic [WIDTH:0] w_cat;
  logic [CW-1:0] r_cnt;
  logic r_br, r_busy, r_done, r_bout, w_d, w_bo, w_last, w_accept;
  assign w_d = r_a[0] ^ r_b[0] ^ r_br;
  assign w_bo = (~r_a[0] & r_b[0]) | (~r_a[0] & r_br) | (r_b[0] & r_br);
  // concatenate then drop the LSB so WIDTH=1 needs no empty slice
  assign w_cat = {w_d, r_r};
  assign w_rn = w_cat[WIDTH:1];
  assign w_last = r_cnt == CW'(WIDTH - 1);
  assign w_accept = (r_state != RUN) && start;
  always_comb begin
    w_next = (r_state == RUN) ? (w_last ? FIN : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      r_r <= '0;
      r_br <= 1'b0;
      r_cnt <= '0;
      r_dif <= '0;
      r_bout <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy <= w_next == RUN;
      r_done <= w_next == FIN;
      if (w_accept) begin
        r_a <= a;
        r_b <= b;
        r_br <= 1'b0;
        r_cnt <= '0;
        r_r <= '0;
      end else if (r_state == RUN) begin
        r_a <= r_a >> 1;
        r_b <= r_b >> 1;
        r_br <= w_bo;
        r_cnt <= r_cnt + CW'(1);
        r_r <= w_rn;
        if (w_last) begin
          r_dif <= w_rn;
          r_bout <= w_bo;
        end
      end
    end
  end
  assign busy = r_busy;
  assign done = r_done;
  assign dif = r_dif;
  assign bout = r_bout;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: directed scoreboard bench for WIDTH=8 and WIDTH=1 instances.
module tb_serial_sub_ctrl;
  logic clk = 0, rst = 1;
  logic s8 = 0, s1 = 0;
  logic [7:0] a8 = 0, b8 = 0, dif8;
  logic a1 = 0, b1 = 0, dif1;
  logic busy8, done8, bout8, busy1, done1, bout1;
  logic [8:0] q8[$];
  logic [1:0] q1[$];
  int n_chk = 0, n_fail = 0;
  int n, nb, nd;

  serial_sub_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .dif(dif8), .bout(bout8));
  serial_sub_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .dif(dif1), .bout(bout1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) chk("done8_unexpected", 1, 0);
      else chk("result8", {23'd0, bout8, dif8}, {23'd0, q8.pop_front()});
    end
    if (done1) begin
      if (q1.size() == 0) chk("done1_unexpected", 1, 0);
      else chk("result1", {30'd0, bout1, dif1}, {30'd0, q1.pop_front()});
    end
  end

  task automatic drive8(input logic [7:0] x, input logic [7:0] y);
    s8 = 1; a8 = x; b8 = y;
    q8.push_back({x < y, 8'(x - y)});
  endtask

  task automatic drive1(input logic x, input logic y);
    s1 = 1; a1 = x; b1 = y;
    q1.push_back({x < y, x ^ y});
  endtask

  task automatic wait_done(input bit one, output int cyc, output int nbusy);
    cyc = 0; nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      s8 = 0; s1 = 0;
      cyc++;
      if (one ? done1 : done8) return;
      nbusy += int'(one ? busy1 : busy8);
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic quiet8(input int cycles, output int dones);
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      dones += int'(done8);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_dif", dif8, 0);
    chk("rst_bout", bout8, 0);
    rst = 0;
    @(negedge clk);
    drive8(8'h5A, 8'h3C);
    wait_done(0, n, nb);
    chk("lat_5a", n, 9);
    chk("busy_5a", nb, 8);
    drive8(8'h00, 8'h01);
    wait_done(0, n, nb);
    drive8(8'h01, 8'hFF);
    wait_done(0, n, nb);
    drive8(8'h80, 8'h80);
    wait_done(0, n, nb);
    drive8(8'hFF, 8'h00);
    wait_done(0, n, nb);
    chk("b2b_spacing", n, 9);
    chk("b2b_busy", nb, 8);
    @(negedge clk);
    chk("fin_to_idle", {busy8, done8}, 0);
    drive8(8'h10, 8'h01);
    repeat (3) @(negedge clk);
    chk("dif_stable_run", dif8, 8'hFF);
    s8 = 1; a8 = 8'h00; b8 = 8'hFF;
    wait_done(0, n, nb);
    chk("ignore_lat", n, 6);
    quiet8(12, nd);
    chk("ignore_one_done", nd, 0);
    drive8(8'h33, 8'h11);
    repeat (4) @(negedge clk);
    s8 = 0;
    rst = 1;
    void'(q8.pop_back());
    @(negedge clk);
    rst = 0;
    chk("midrst_busy", busy8, 0);
    chk("midrst_done", done8, 0);
    chk("midrst_dif", dif8, 0);
    chk("midrst_bout", bout8, 0);
    quiet8(12, nd);
    chk("midrst_no_done", nd, 0);
    drive8(8'hC3, 8'h3C);
    wait_done(0, n, nb);
    chk("fresh_lat", n, 9);
    drive1(1, 0);
    wait_done(1, n, nb);
    chk("w1_lat_a", n, 2);
    drive1(0, 1);
    wait_done(1, n, nb);
    chk("w1_lat_b", n, 2);
    drive1(1, 1);
    wait_done(1, n, nb);
    chk("w1_lat_c", n, 2);
    @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
